// File: rtl/fpu_pkg.sv
// Shared definitions for the iterative significand divide/sqrt engine.
package fpu_pkg;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_SQRT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Guard/round/sticky positions below the mantissa in the result word.
  localparam int unsigned GRS_S = 0;
  localparam int unsigned GRS_R = 1;
  localparam int unsigned GRS_G = 2;
  localparam int unsigned GRS_W = 3;

  function automatic int unsigned nit_d(input int unsigned sig_w);
    return sig_w + 3;
  endfunction

  function automatic int unsigned nit_s(input int unsigned sig_w);
    return sig_w + 2;
  endfunction

endpackage

// File: rtl/fpu_divsqrt_step.sv
// One restoring iteration: trial subtract, keep the difference when non-negative.
module fpu_divsqrt_step #(
  parameter int unsigned W = 29
) (
  input  logic [W-1:0] pr,
  input  logic [W-1:0] sub,
  output logic         q_bit_c,
  output logic [W-1:0] rem_next_c
);

  logic [W:0] diff;

  always_comb begin
    diff       = {1'b0, pr} - {1'b0, sub};
    q_bit_c    = ~diff[W];
    rem_next_c = q_bit_c ? diff[W-1:0] : pr;
  end

endmodule

// File: rtl/fpu_divsqrt_iter.sv
// Iterative radix-2 significand divide / square root with one-bit post-normalisation
// producing {mantissa, G, R, S} for the downstream rounder.
module fpu_divsqrt_iter
  import fpu_pkg::*;
#(
  parameter int unsigned SIG_W = 24,
  parameter int unsigned EXP_W = 10,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op,
  input  logic                   in_odd,
  input  logic [SIG_W-1:0]       in_a,
  input  logic [SIG_W-1:0]       in_b,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic                   kill,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIG_W+GRS_W-1:0] out_sig,
  output logic [EXP_W-1:0]       out_exp,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic                   busy
);

  localparam int unsigned NIT_D = nit_d(SIG_W);
  localparam int unsigned NIT_S = nit_s(SIG_W);
  localparam int unsigned CNT_W = $clog2(SIG_W + 4);
  localparam int unsigned TW    = SIG_W + 5;
  localparam int unsigned RAD_W = 2 * SIG_W + 4;
  localparam int unsigned Q_W   = SIG_W + 3;

  state_e           state;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic [SIG_W-1:0] b_q;
  logic [RAD_W-1:0] rad_q;
  logic [TW-1:0]    rem_q;
  logic [Q_W-1:0]   q_q;
  logic [EXP_W-1:0] exp_q;
  logic [TAG_W-1:0] tag_q;

  logic [TW-1:0]    pr_c;
  logic [TW-1:0]    sub_c;
  logic             q_bit_c;
  logic [TW-1:0]    rem_next_c;
  logic             last_c;
  logic             sticky_c;
  logic [SIG_W:0]   rad_init_c;

  // Divide keeps the remainder pre-doubled against 2b; sqrt brings in two radicand bits per step.
  always_comb begin
    rad_init_c = in_odd ? {in_a, 1'b0} : {1'b0, in_a};
    sticky_c   = (rem_q != '0);
    if (op_q == OP_SQRT) begin
      pr_c   = TW'({rem_q, rad_q[RAD_W-1 -: 2]});
      sub_c  = TW'({q_q, 2'b01});
      last_c = (cnt_q == CNT_W'(NIT_S - 1));
    end else begin
      pr_c   = TW'({rem_q, 1'b0});
      sub_c  = TW'({b_q, 1'b0});
      last_c = (cnt_q == CNT_W'(NIT_D - 1));
    end
  end

  fpu_divsqrt_step #(.W(TW)) u_step (
    .pr         (pr_c),
    .sub        (sub_c),
    .q_bit_c    (q_bit_c),
    .rem_next_c (rem_next_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_sig   <= '0;
      out_exp   <= '0;
      out_tag   <= '0;
      cnt_q     <= '0;
      op_q      <= OP_DIV;
      b_q       <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      exp_q     <= '0;
      tag_q     <= '0;
    end else if (kill) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= in_op;
            b_q      <= in_b;
            exp_q    <= in_exp;
            tag_q    <= in_tag;
            cnt_q    <= '0;
            q_q      <= '0;
            rem_q    <= (in_op == OP_SQRT) ? '0 : TW'(in_a);
            rad_q    <= {rad_init_c, (SIG_W + 3)'(0)};
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_op == OP_DIV && !in_b[SIG_W-1]) begin
              out_err   <= 1'b1;
              out_sig   <= '0;
              out_exp   <= in_exp;
              out_tag   <= in_tag;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          q_q   <= {q_q[Q_W-2:0], q_bit_c};
          rem_q <= rem_next_c;
          rad_q <= rad_q << 2;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_c) state <= ST_NORM;
        end
        ST_NORM: begin
          out_valid <= 1'b1;
          out_tag   <= tag_q;
          state     <= ST_DONE;
          if (op_q == OP_SQRT) begin
            out_sig <= {q_q[Q_W-2:0], sticky_c};
            out_exp <= exp_q;
          end else if (q_q[Q_W-1]) begin
            out_sig <= {q_q[Q_W-1:1], q_q[0] | sticky_c};
            out_exp <= exp_q;
          end else begin
            out_sig <= {q_q[Q_W-2:0], sticky_c};
            out_exp <= exp_q - EXP_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Scoreboard bench for fpu_divsqrt_iter: directed cases plus randomized operands
// against an arithmetic reference (integer quotient / integer square root).
module tb_fpu_divsqrt_iter;

  localparam int unsigned SIG_W = 24;
  localparam int unsigned EXP_W = 10;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned OUT_W = SIG_W + 3;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic             in_odd;
  logic [SIG_W-1:0] in_a;
  logic [SIG_W-1:0] in_b;
  logic [EXP_W-1:0] in_exp;
  logic [TAG_W-1:0] in_tag;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sig;
  logic [EXP_W-1:0] out_exp;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  typedef struct packed {
    logic [OUT_W-1:0] sig;
    logic [EXP_W-1:0] exp;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rnd_en = 0;

  fpu_divsqrt_iter #(.SIG_W(SIG_W), .EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_odd    (in_odd),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_exp    (in_exp),
    .in_tag    (in_tag),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sig   (out_sig),
    .out_exp   (out_exp),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: quotient = floor(a * 2^(SIG_W+2) / b), root = isqrt(radicand * 2^(SIG_W+3)).
  function automatic exp_t model(input logic op, input logic odd, input logic [SIG_W-1:0] a,
                                 input logic [SIG_W-1:0] b, input logic [EXP_W-1:0] e,
                                 input logic [TAG_W-1:0] tag);
    exp_t r;
    longint unsigned num, q, rm, x, m, lo, hi, mid;
    r.tag = tag;
    r.err = 1'b0;
    r.exp = e;
    r.sig = '0;
    if (op == 1'b0) begin
      if (b[SIG_W-1] == 1'b0) begin
        r.err = 1'b1;
      end else begin
        num = 64'(a) << (SIG_W + 2);
        q   = num / 64'(b);
        rm  = num % 64'(b);
        if (q >= (64'd1 << (SIG_W + 2))) begin
          r.sig = OUT_W'(q | 64'(rm != 0));
        end else begin
          r.sig = OUT_W'((q << 1) | 64'(rm != 0));
          r.exp = e - 1'b1;
        end
      end
    end else begin
      x  = odd ? (64'(a) << 1) : 64'(a);
      m  = x << (SIG_W + 3);
      lo = 0;
      hi = 64'd1 << (SIG_W + 3);
      while (hi - lo > 1) begin
        mid = (lo + hi) >> 1;
        if (mid * mid <= m) lo = mid;
        else hi = mid;
      end
      r.sig = OUT_W'((lo << 1) | 64'(lo * lo != m));
    end
    return r;
  endfunction

  // Monitor: a result is consumed on any edge with out_valid & out_ready and no kill.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (!reset && out_valid && out_ready && !kill) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got tag 0x%0h, expected no result", out_tag);
        end else begin
          e = sb.pop_front();
          check("out_sig", 64'(out_sig), 64'(e.sig));
          if (!e.err) check("out_exp", 64'(out_exp), 64'(e.exp));
          check("out_tag", 64'(out_tag), 64'(e.tag));
          check("out_err", 64'(out_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  // Returns right after the acceptance edge.
  task automatic issue(input logic op, input logic odd, input logic [SIG_W-1:0] a,
                       input logic [SIG_W-1:0] b, input logic [EXP_W-1:0] e,
                       input logic [TAG_W-1:0] tag, input bit push, input exp_t ex);
    wait_ready();
    in_op = op; in_odd = odd; in_a = a; in_b = b; in_exp = e; in_tag = tag;
    in_valid = 1'b1;
    if (push) sb.push_back(ex);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag_s);
    check({tag_s, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag_s, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag_s, "_busy"},      64'(busy),      64'd0);
    check({tag_s, "_out_err"},   64'(out_err),   64'd0);
    check({tag_s, "_out_sig"},   64'(out_sig),   64'd0);
    check({tag_s, "_out_exp"},   64'(out_exp),   64'd0);
    check({tag_s, "_out_tag"},   64'(out_tag),   64'd0);
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (out_valid) seen++;
    end
  endtask

  initial begin
    exp_t none;
    exp_t ex;
    int   n;
    logic             r_op, r_odd;
    logic [SIG_W-1:0] r_a, r_b;
    logic [EXP_W-1:0] r_e;
    logic [TAG_W-1:0] r_t;

    none = '0;
    reset = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_odd = 1'b0; in_a = '0; in_b = '0;
    in_exp = '0; in_tag = '0; kill = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check_reset_vals("rst");
    reset = 1'b0;
    step();

    // 1.5 / 1.0
    ex = '{sig: 27'h6000000, exp: 10'd5, tag: 4'h1, err: 1'b0};
    issue(1'b0, 1'b0, 24'hC00000, 24'h800000, 10'd5, 4'h1, 1, ex);
    wait_valid(n);
    check("div_latency", 64'(n), 64'd28);

    // 1.0 / 1.5: mantissa AAAAAA, G=1 R=0 S=1, exponent decremented
    ex = '{sig: {24'hAAAAAA, 3'b101}, exp: 10'h3FF, tag: 4'h2, err: 1'b0};
    issue(1'b0, 1'b0, 24'h800000, 24'hC00000, 10'd0, 4'h2, 1, ex);
    wait_valid(n);
    check("div2_latency", 64'(n), 64'd28);

    // sqrt(2.25) and sqrt(1.0)
    ex = '{sig: 27'h6000000, exp: 10'd3, tag: 4'h3, err: 1'b0};
    issue(1'b1, 1'b1, 24'h900000, 24'h000000, 10'd3, 4'h3, 1, ex);
    wait_valid(n);
    check("sqrt_latency", 64'(n), 64'd27);
    ex = '{sig: 27'h4000000, exp: 10'd3, tag: 4'h4, err: 1'b0};
    issue(1'b1, 1'b0, 24'h800000, 24'h123456, 10'd3, 4'h4, 1, ex);
    wait_valid(n);

    // Unnormalised divisor: result in the cycle after acceptance
    ex = '{sig: '0, exp: 10'd0, tag: 4'h5, err: 1'b1};
    issue(1'b0, 1'b0, 24'hC00000, 24'h400000, 10'd9, 4'h5, 1, ex);
    wait_valid(n);
    check("err_latency", 64'(n), 64'd0);
    step();
    check("err_cleared", 64'(out_err), 64'd0);
    check("err_valid_cleared", 64'(out_valid), 64'd0);

    // Backpressure with a held request
    out_ready = 1'b0;
    ex = '{sig: 27'h6000000, exp: 10'd7, tag: 4'h6, err: 1'b0};
    issue(1'b0, 1'b0, 24'hC00000, 24'h800000, 10'd7, 4'h6, 1, ex);
    wait_valid(n);
    in_op = 1'b1; in_odd = 1'b1; in_a = 24'h900000; in_b = '0; in_exp = 10'd2; in_tag = 4'h8;
    in_valid = 1'b1;
    ex = '{sig: 27'h6000000, exp: 10'd2, tag: 4'h8, err: 1'b0};
    sb.push_back(ex);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_sig_hold", 64'(out_sig), 64'h6000000);
      check("bp_tag_hold", 64'(out_tag), 64'h6);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_idle_ready", 64'(in_ready), 64'd1);
    check("bp_idle_busy", 64'(busy), 64'd0);
    step();
    check("bp_held_accepted", 64'(busy), 64'd1);
    in_valid = 1'b0;
    wait_valid(n);
    check("bp_held_latency", 64'(n), 64'd27);

    // Kill mid-CALC: dropped result never appears, next op completes with its own tag
    issue(1'b0, 1'b0, 24'hF00000, 24'h900000, 10'd1, 4'h7, 0, none);
    repeat (10) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill_in_ready", 64'(in_ready), 64'd1);
    check("kill_busy", 64'(busy), 64'd0);
    count_valid(40, n);
    check("kill_no_valid", 64'(n), 64'd0);
    ex = '{sig: {24'hAAAAAA, 3'b101}, exp: 10'h3FF, tag: 4'h9, err: 1'b0};
    issue(1'b0, 1'b0, 24'h800000, 24'hC00000, 10'd0, 4'h9, 1, ex);
    wait_valid(n);
    check("post_kill_latency", 64'(n), 64'd28);

    // Asynchronous reset mid-CALC
    issue(1'b1, 1'b0, 24'hB00000, 24'h0, 10'd4, 4'hB, 0, none);
    repeat (5) step();
    reset = 1'b1;
    #2;
    check_reset_vals("midrst");
    step();
    reset = 1'b0;
    count_valid(40, n);
    check("midrst_no_valid", 64'(n), 64'd0);

    // Kill beats out_ready in DONE
    out_ready = 1'b0;
    issue(1'b0, 1'b0, 24'hC00000, 24'hA00000, 10'd6, 4'hA, 0, none);
    wait_valid(n);
    kill = 1'b1;
    out_ready = 1'b1;
    step();
    kill = 1'b0;
    check("kill_done_valid", 64'(out_valid), 64'd0);
    check("kill_done_ready", 64'(in_ready), 64'd1);

    // Operand extremes
    issue(1'b0, 1'b0, 24'hFFFFFF, 24'h800000, 10'd12, 4'hC, 1,
          model(1'b0, 1'b0, 24'hFFFFFF, 24'h800000, 10'd12, 4'hC));
    issue(1'b0, 1'b0, 24'h800000, 24'hFFFFFF, 10'd0, 4'hD, 1,
          model(1'b0, 1'b0, 24'h800000, 24'hFFFFFF, 10'd0, 4'hD));
    issue(1'b1, 1'b1, 24'hFFFFFF, 24'h0, 10'h200, 4'hE, 1,
          model(1'b1, 1'b1, 24'hFFFFFF, 24'h0, 10'h200, 4'hE));
    issue(1'b1, 1'b1, 24'h800000, 24'h0, 10'd1, 4'hF, 1,
          model(1'b1, 1'b1, 24'h800000, 24'h0, 10'd1, 4'hF));

    // Randomized operands with random output backpressure
    rnd_en = 1;
    for (int i = 0; i < 60; i++) begin
      r_op  = 1'($urandom_range(0, 1));
      r_odd = 1'($urandom_range(0, 1));
      r_a   = {1'b1, 23'($urandom)};
      r_b   = {($urandom_range(0, 15) != 0), 23'($urandom)};
      r_e   = EXP_W'($urandom);
      r_t   = TAG_W'($urandom);
      issue(r_op, r_odd, r_a, r_b, r_e, r_t, 1, model(r_op, r_odd, r_a, r_b, r_e, r_t));
    end
    rnd_en = 0;
    step();
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
